// File: rtl/commit_retire_unit_pkg.sv
// Shared types for the commit/retire unit: issue numbers (pkg_top) and table entries (pkg_mpu).
package pkg_top;
  typedef logic [7:0] issue_no_t;
endpackage

package pkg_mpu;
  import pkg_top::*;

  typedef struct packed {
    logic      v;
    logic      committed;
    issue_no_t issue_no;
  } retire_entry_t;
endpackage

// File: rtl/commit_retire_unit_if.sv
// Issue/commit/retire handshake bundle for commit_retire_unit.
// O_Error exists only when COMMIT_RETIRE_ERR_CHECK_EN is defined.
interface commit_retire_unit_if;
  import pkg_top::*;

  logic      I_Issue_Req;
  issue_no_t I_Issue_No;
  logic      I_Commit_Req;
  issue_no_t I_Commit_No;
  logic      O_Commit_Grant;
  logic      O_Retire_Valid;
  issue_no_t O_Retire_No;
  logic      I_Retire_Ready;
  logic      O_Full;
  logic      O_Empty;
`ifdef COMMIT_RETIRE_ERR_CHECK_EN
  logic      O_Error;
`endif

  modport slave (
    input  I_Issue_Req, I_Issue_No, I_Commit_Req, I_Commit_No, I_Retire_Ready,
    output O_Commit_Grant, O_Retire_Valid, O_Retire_No, O_Full, O_Empty
`ifdef COMMIT_RETIRE_ERR_CHECK_EN
    , output O_Error
`endif
  );

  modport master (
    output I_Issue_Req, I_Issue_No, I_Commit_Req, I_Commit_No, I_Retire_Ready,
    input  O_Commit_Grant, O_Retire_Valid, O_Retire_No, O_Full, O_Empty
`ifdef COMMIT_RETIRE_ERR_CHECK_EN
    , input O_Error
`endif
  );
endinterface

// File: rtl/commit_retire_unit_ringbuffctrl.sv
// Read/write pointer and occupancy control for a power-of-two ring buffer.
module RingBuffCTRL #(
  parameter int unsigned NUM_ENTRY = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         We,
  input  logic                         Re,
  output logic [$clog2(NUM_ENTRY)-1:0] WPtr,
  output logic [$clog2(NUM_ENTRY)-1:0] RPtr,
  output logic                         Full,
  output logic                         Empty
);
  localparam int unsigned PW = $clog2(NUM_ENTRY);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      WPtr  <= '0;
      RPtr  <= '0;
      count <= '0;
    end else begin
      if (We) WPtr <= WPtr + PW'(1);
      if (Re) RPtr <= RPtr + PW'(1);
      case ({We, Re})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign Full  = (count == CW'(NUM_ENTRY));
  assign Empty = (count == '0);
endmodule

// File: rtl/commit_retire_unit.sv
// Outstanding-issue table: allocates on issue, marks entries committed, retires in issue order.
// Optional sticky O_Error when COMMIT_RETIRE_ERR_CHECK_EN is defined.
module commit_retire_unit
  import pkg_top::*;
  import pkg_mpu::*;
#(
  parameter int unsigned BUFF_SIZE = 4
) (
  input logic                 clock,
  input logic                 reset,
  commit_retire_unit_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(BUFF_SIZE);

  retire_entry_t              table_q [BUFF_SIZE];
  retire_entry_t              head;
  logic [PTR_W-1:0]           wptr;
  logic [PTR_W-1:0]           rptr;
  logic                       full;
  logic                       empty;
  logic                       allocate;
  logic                       retire;
  logic [BUFF_SIZE-1:0]       commit_match;

  RingBuffCTRL #(.NUM_ENTRY(BUFF_SIZE)) u_ring (
    .clock (clock),
    .reset (reset),
    .We    (allocate),
    .Re    (retire),
    .WPtr  (wptr),
    .RPtr  (rptr),
    .Full  (full),
    .Empty (empty)
  );

  assign head     = table_q[rptr];
  assign allocate = bus.I_Issue_Req & ~full;
  assign retire   = head.v & head.committed & bus.I_Retire_Ready;

  // Only already-valid entries match, so a same-cycle allocation is never committed.
  always_comb begin
    commit_match = '0;
    for (int unsigned i = 0; i < BUFF_SIZE; i++) begin
      commit_match[i] = bus.I_Commit_Req & table_q[i].v & ~table_q[i].committed &
                        (table_q[i].issue_no == bus.I_Commit_No);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < BUFF_SIZE; i++) table_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < BUFF_SIZE; i++) begin
        if (commit_match[i]) table_q[i].committed <= 1'b1;
        if (retire && (rptr == PTR_W'(i))) table_q[i] <= '0;
        if (allocate && (wptr == PTR_W'(i)))
          table_q[i] <= '{v: 1'b1, committed: 1'b0, issue_no: bus.I_Issue_No};
      end
    end
  end

  assign bus.O_Commit_Grant = bus.I_Commit_Req;
  assign bus.O_Retire_Valid = head.v & head.committed;
  assign bus.O_Retire_No    = head.issue_no;
  assign bus.O_Full         = full;
  assign bus.O_Empty        = empty;

`ifdef COMMIT_RETIRE_ERR_CHECK_EN
  logic error_q;

  always_ff @(posedge clock) begin
    if (reset) error_q <= 1'b0;
    else if ((bus.I_Commit_Req && (commit_match == '0)) || (bus.I_Issue_Req && full))
      error_q <= 1'b1;
  end

  assign bus.O_Error = error_q;
`endif
endmodule

// File: tb/tb_commit_retire_unit.sv
// Directed self-checking bench for commit_retire_unit (default BUFF_SIZE = 4).
module tb_commit_retire_unit;
  import pkg_top::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  commit_retire_unit_if bus ();

  commit_retire_unit #(.BUFF_SIZE(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.I_Issue_Req    = 1'b0;
    bus.I_Issue_No     = '0;
    bus.I_Commit_Req   = 1'b0;
    bus.I_Commit_No    = '0;
    bus.I_Retire_Ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic issue(input issue_no_t n);
    bus.I_Issue_Req = 1'b1;
    bus.I_Issue_No  = n;
    tick();
    bus.I_Issue_Req = 1'b0;
  endtask

  task automatic commit(input issue_no_t n);
    bus.I_Commit_Req = 1'b1;
    bus.I_Commit_No  = n;
    tick();
    bus.I_Commit_Req = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    bus.I_Commit_Req = 1'b1;
    bus.I_Issue_Req  = 1'b1;
    bus.I_Issue_No   = 8'd21;
    tick();
    tick();
    checks++; if (bus.O_Commit_Grant !== 1'b1) begin errors++; $display("FAIL reset_grant: got %b expected 1", bus.O_Commit_Grant); end
    checks++; if (bus.O_Empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.O_Empty); end
    checks++; if (bus.O_Full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.O_Full); end
    checks++; if (bus.O_Retire_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.O_Retire_Valid); end
    checks++; if (bus.O_Retire_No !== 8'd0) begin errors++; $display("FAIL reset_no: got %0d expected 0", bus.O_Retire_No); end
`ifdef COMMIT_RETIRE_ERR_CHECK_EN
    checks++; if (bus.O_Error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bus.O_Error); end
`endif
    reset = 1'b0;
    idle();
    tick();
    checks++; if (bus.O_Empty !== 1'b1) begin errors++; $display("FAIL reset_no_alloc: empty got %b expected 1", bus.O_Empty); end
  endtask

  task automatic test_in_order();
    do_reset();
    bus.I_Retire_Ready = 1'b1;
    issue(8'd5);
    issue(8'd6);
    issue(8'd7);
    checks++; if (bus.O_Empty !== 1'b0) begin errors++; $display("FAIL order_empty: got %b expected 0", bus.O_Empty); end
    bus.I_Commit_Req = 1'b1;
    bus.I_Commit_No  = 8'd7;
    #1;
    checks++; if (bus.O_Commit_Grant !== 1'b1) begin errors++; $display("FAIL order_grant: got %b expected 1", bus.O_Commit_Grant); end
    tick();
    checks++; if (bus.O_Retire_Valid !== 1'b0) begin errors++; $display("FAIL order_wait_older: valid got %b expected 0", bus.O_Retire_Valid); end
    bus.I_Commit_No = 8'd5;
    tick();
    checks++; if (bus.O_Retire_Valid !== 1'b1 || bus.O_Retire_No !== 8'd5) begin errors++; $display("FAIL order_first: valid/no got %b/%0d expected 1/5", bus.O_Retire_Valid, bus.O_Retire_No); end
    bus.I_Commit_No = 8'd6;
    tick();
    bus.I_Commit_Req = 1'b0;
    #1;
    checks++; if (bus.O_Commit_Grant !== 1'b0) begin errors++; $display("FAIL order_grant_low: got %b expected 0", bus.O_Commit_Grant); end
    checks++; if (bus.O_Retire_Valid !== 1'b1 || bus.O_Retire_No !== 8'd6) begin errors++; $display("FAIL order_second: valid/no got %b/%0d expected 1/6", bus.O_Retire_Valid, bus.O_Retire_No); end
    tick();
    checks++; if (bus.O_Retire_Valid !== 1'b1 || bus.O_Retire_No !== 8'd7) begin errors++; $display("FAIL order_third: valid/no got %b/%0d expected 1/7", bus.O_Retire_Valid, bus.O_Retire_No); end
    tick();
    checks++; if (bus.O_Retire_Valid !== 1'b0 || bus.O_Empty !== 1'b1) begin errors++; $display("FAIL order_drained: valid/empty got %b/%b expected 0/1", bus.O_Retire_Valid, bus.O_Empty); end
    bus.I_Retire_Ready = 1'b0;
  endtask

  task automatic test_full_wrap();
    issue_no_t exp_no [4];
    exp_no[0] = 8'd1; exp_no[1] = 8'd2; exp_no[2] = 8'd3; exp_no[3] = 8'd9;
    do_reset();
    for (int i = 0; i < 4; i++) issue(issue_no_t'(i));
    checks++; if (bus.O_Full !== 1'b1) begin errors++; $display("FAIL full_set: got %b expected 1", bus.O_Full); end
    issue(8'd9);
    checks++; if (bus.O_Full !== 1'b1 || bus.O_Retire_Valid !== 1'b0) begin errors++; $display("FAIL full_drop: full/valid got %b/%b expected 1/0", bus.O_Full, bus.O_Retire_Valid); end
    commit(8'd0);
    checks++; if (bus.O_Retire_Valid !== 1'b1 || bus.O_Retire_No !== 8'd0) begin errors++; $display("FAIL full_head: valid/no got %b/%0d expected 1/0", bus.O_Retire_Valid, bus.O_Retire_No); end
    bus.I_Retire_Ready = 1'b1;
    tick();
    bus.I_Retire_Ready = 1'b0;
    checks++; if (bus.O_Full !== 1'b0) begin errors++; $display("FAIL full_clear: got %b expected 0", bus.O_Full); end
    issue(8'd9);
    checks++; if (bus.O_Full !== 1'b1) begin errors++; $display("FAIL wrap_refill: full got %b expected 1", bus.O_Full); end
    commit(8'd9);
    commit(8'd1);
    commit(8'd2);
    commit(8'd3);
    bus.I_Retire_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.O_Retire_Valid !== 1'b1 || bus.O_Retire_No !== exp_no[i]) begin errors++; $display("FAIL wrap_retire%0d: valid/no got %b/%0d expected 1/%0d", i, bus.O_Retire_Valid, bus.O_Retire_No, exp_no[i]); end
      tick();
    end
    checks++; if (bus.O_Empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", bus.O_Empty); end
    bus.I_Retire_Ready = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    issue(8'd3);
    commit(8'd3);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.O_Retire_Valid !== 1'b1 || bus.O_Retire_No !== 8'd3) begin errors++; $display("FAIL hold_cycle%0d: valid/no got %b/%0d expected 1/3", i, bus.O_Retire_Valid, bus.O_Retire_No); end
      tick();
    end
    bus.I_Retire_Ready = 1'b1;
    tick();
    bus.I_Retire_Ready = 1'b0;
    checks++; if (bus.O_Retire_Valid !== 1'b0 || bus.O_Empty !== 1'b1) begin errors++; $display("FAIL hold_single_retire: valid/empty got %b/%b expected 0/1", bus.O_Retire_Valid, bus.O_Empty); end
  endtask

  task automatic test_unknown_commit();
    do_reset();
    issue(8'd1);
    bus.I_Commit_Req = 1'b1;
    bus.I_Commit_No  = 8'd12;
    #1;
    checks++; if (bus.O_Commit_Grant !== 1'b1) begin errors++; $display("FAIL unknown_grant: got %b expected 1", bus.O_Commit_Grant); end
    tick();
    bus.I_Commit_Req = 1'b0;
    checks++; if (bus.O_Retire_Valid !== 1'b0 || bus.O_Empty !== 1'b0) begin errors++; $display("FAIL unknown_nochange: valid/empty got %b/%b expected 0/0", bus.O_Retire_Valid, bus.O_Empty); end
`ifdef COMMIT_RETIRE_ERR_CHECK_EN
    checks++; if (bus.O_Error !== 1'b1) begin errors++; $display("FAIL unknown_error: got %b expected 1", bus.O_Error); end
    tick();
    checks++; if (bus.O_Error !== 1'b1) begin errors++; $display("FAIL unknown_error_sticky: got %b expected 1", bus.O_Error); end
`endif
    commit(8'd1);
    checks++; if (bus.O_Retire_Valid !== 1'b1 || bus.O_Retire_No !== 8'd1) begin errors++; $display("FAIL unknown_entry_intact: valid/no got %b/%0d expected 1/1", bus.O_Retire_Valid, bus.O_Retire_No); end
  endtask

  task automatic test_full_retire_same_cycle();
    issue_no_t exp_no [3];
    exp_no[0] = 8'd1; exp_no[1] = 8'd2; exp_no[2] = 8'd3;
    do_reset();
    for (int i = 0; i < 4; i++) issue(issue_no_t'(i));
    commit(8'd0);
    bus.I_Issue_Req    = 1'b1;
    bus.I_Issue_No     = 8'd8;
    bus.I_Retire_Ready = 1'b1;
    tick();
    bus.I_Issue_Req    = 1'b0;
    bus.I_Retire_Ready = 1'b0;
    checks++; if (bus.O_Full !== 1'b0 || bus.O_Empty !== 1'b0) begin errors++; $display("FAIL fullret_count: full/empty got %b/%b expected 0/0", bus.O_Full, bus.O_Empty); end
    commit(8'd1);
    commit(8'd2);
    commit(8'd3);
    commit(8'd8);
    bus.I_Retire_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.O_Retire_Valid !== 1'b1 || bus.O_Retire_No !== exp_no[i]) begin errors++; $display("FAIL fullret_retire%0d: valid/no got %b/%0d expected 1/%0d", i, bus.O_Retire_Valid, bus.O_Retire_No, exp_no[i]); end
      tick();
    end
    checks++; if (bus.O_Empty !== 1'b1 || bus.O_Retire_Valid !== 1'b0) begin errors++; $display("FAIL fullret_dropped: empty/valid got %b/%b expected 1/0", bus.O_Empty, bus.O_Retire_Valid); end
    bus.I_Retire_Ready = 1'b0;
  endtask

  task automatic test_same_cycle_commit();
    do_reset();
    bus.I_Issue_Req  = 1'b1;
    bus.I_Issue_No   = 8'd4;
    bus.I_Commit_Req = 1'b1;
    bus.I_Commit_No  = 8'd4;
    tick();
    idle();
    tick();
    checks++; if (bus.O_Retire_Valid !== 1'b0 || bus.O_Empty !== 1'b0) begin errors++; $display("FAIL samecycle_nomatch: valid/empty got %b/%b expected 0/0", bus.O_Retire_Valid, bus.O_Empty); end
    commit(8'd4);
    checks++; if (bus.O_Retire_Valid !== 1'b1 || bus.O_Retire_No !== 8'd4) begin errors++; $display("FAIL samecycle_later: valid/no got %b/%0d expected 1/4", bus.O_Retire_Valid, bus.O_Retire_No); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(8'd1);
    issue(8'd2);
    issue(8'd3);
    commit(8'd2);
    do_reset();
    checks++; if (bus.O_Empty !== 1'b1 || bus.O_Retire_Valid !== 1'b0) begin errors++; $display("FAIL midreset_clear: empty/valid got %b/%b expected 1/0", bus.O_Empty, bus.O_Retire_Valid); end
    bus.I_Retire_Ready = 1'b1;
    commit(8'd1);
    checks++; if (bus.O_Retire_Valid !== 1'b0 || bus.O_Empty !== 1'b1) begin errors++; $display("FAIL midreset_stale_commit: valid/empty got %b/%b expected 0/1", bus.O_Retire_Valid, bus.O_Empty); end
    bus.I_Retire_Ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_in_order();
    test_full_wrap();
    test_hold();
    test_unknown_commit();
    test_full_retire_same_cycle();
    test_same_cycle_commit();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
